// File: rtl/sim_exit_ctrl.sv
// Simulation harness controller: sequences the DUT reset, watches N prioritised exit-code
// sources and an activity watchdog, then drains for a fixed window before requesting $finish.
module sim_exit_ctrl #(
  parameter int N_SRC           = 2,
  parameter int CODE_W          = 32,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int WDT_CYCLES      = 1000000,
  parameter int DRAIN_CYCLES    = 64,
  parameter int CNT_W           = 48,
  localparam int SRC_W          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_SRC*CODE_W-1:0] exit_code_i,
  input  logic                    activity_i,
  input  logic                    ext_rst_req_i,
  output logic                    dut_rst_no,
  output logic                    running_o,
  output logic                    exit_valid_o,
  output logic [CODE_W-1:0]       exit_code_o,
  output logic [SRC_W-1:0]        exit_src_o,
  output logic                    timeout_o,
  output logic                    finish_o,
  output logic [CNT_W-1:0]        cycle_cnt_o,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int HOLD_W  = 16;
  localparam int WDT_W   = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [WDT_W-1:0]   WDT_LAST   = WDT_W'(WDT_CYCLES - 1);
  // A zero drain length behaves like a single DRAIN cycle: DONE follows the first one.
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? '0 : DRAIN_W'(DRAIN_CYCLES - 1);
  localparam bit                 WDT_EN     = (WDT_CYCLES != 0);

  state_t              state;
  state_t              state_next;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [WDT_W-1:0]    wdt_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;

  logic                exit_hit;
  logic [SRC_W-1:0]    exit_idx;
  logic [CODE_W-1:0]   exit_code;
  logic                wdt_expire;
  logic                hold_last;
  logic                drain_last;
  logic                do_exit;
  logic                do_tmo;
  logic                do_ext;

  // Scan from the highest index down so the lowest nonzero source wins.
  always_comb begin
    exit_hit  = 1'b0;
    exit_idx  = '0;
    exit_code = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (exit_code_i[k*CODE_W +: CODE_W] != '0) begin
        exit_hit  = 1'b1;
        exit_idx  = SRC_W'(k);
        exit_code = exit_code_i[k*CODE_W +: CODE_W];
      end
    end
  end

  always_comb begin
    wdt_expire = WDT_EN && !activity_i && (wdt_cnt == WDT_LAST);
    hold_last  = (hold_cnt == HOLD_LAST);
    drain_last = (drain_cnt == DRAIN_LAST);
    do_exit    = (state == RUN) && exit_hit;
    do_tmo     = (state == RUN) && !exit_hit && wdt_expire;
    do_ext     = (state == RUN) && !exit_hit && !wdt_expire && ext_rst_req_i;
  end

  always_comb begin
    state_next = state;
    case (state)
      HOLD:    if (hold_last) state_next = RUN;
      RUN: begin
        if (do_exit || do_tmo) state_next = DRAIN;
        else if (do_ext)       state_next = HOLD;
      end
      DRAIN:   if (drain_last) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = HOLD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= HOLD;
    else         state <= state_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt  <= '0;
      wdt_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (do_ext)                          hold_cnt <= '0;
      else if (state == HOLD && !hold_last) hold_cnt <= hold_cnt + HOLD_W'(1);

      if (state == RUN) begin
        if (activity_i || do_ext) wdt_cnt <= '0;
        else                      wdt_cnt <= wdt_cnt + WDT_W'(1);
      end

      if (state == DRAIN && !drain_last) drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_o <= '0;
    end else if (do_ext) begin
      cycle_cnt_o <= '0;
    end else if ((state == RUN || state == DRAIN) && cycle_cnt_o != {CNT_W{1'b1}}) begin
      cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
    end
  end

  // Status outputs are registered views of the state being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dut_rst_no <= 1'b0;
      running_o  <= 1'b0;
      finish_o   <= 1'b0;
    end else begin
      dut_rst_no <= (state_next != HOLD);
      running_o  <= (state_next == RUN);
      finish_o   <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_valid_o <= 1'b0;
      exit_code_o  <= '0;
      exit_src_o   <= '0;
      timeout_o    <= 1'b0;
    end else if (do_exit) begin
      exit_valid_o <= 1'b1;
      exit_code_o  <= exit_code;
      exit_src_o   <= exit_idx;
      timeout_o    <= 1'b0;
    end else if (do_tmo) begin
      exit_valid_o <= 1'b1;
      exit_code_o  <= {CODE_W{1'b1}};
      exit_src_o   <= '0;
      timeout_o    <= 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Scoreboard bench for sim_exit_ctrl: a per-cycle behavioural model predicts each output
// event (DUT reset rise/fall, exit latch, finish) and a negedge monitor checks them.
module tb_sim_exit_ctrl;

  localparam int N_SRC  = 2;
  localparam int CODE_W = 32;
  localparam int HOLD_N = 16;
  localparam int WDT_N  = 100;
  localparam int DRN_N  = 64;
  localparam int CNT_W  = 48;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_EXIT = 2;
  localparam int EV_FIN  = 3;

  localparam int PH_HOLD  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  typedef struct packed {
    logic [1:0]        kind;
    logic [31:0]       stamp;
    logic              run;
    logic              rstn;
    logic              valid;
    logic [CODE_W-1:0] code;
    logic              src;
    logic              tmo;
    logic              fin;
    logic [CNT_W-1:0]  cnt;
  } ev_t;
  localparam int EV_W = $bits(ev_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N_SRC*CODE_W-1:0] exit_code = '0;
  logic                    act = 1'b0;
  logic                    ext = 1'b0;
  logic                    dut_rst_no, running, exit_valid, timeout, finish;
  logic [CODE_W-1:0]       exit_code_q;
  logic [0:0]              exit_src;
  logic [CNT_W-1:0]        cycle_cnt;
  logic [1:0]              state_dbg;

  sim_exit_ctrl #(
    .N_SRC(N_SRC), .CODE_W(CODE_W), .RST_HOLD_CYCLES(HOLD_N),
    .WDT_CYCLES(WDT_N), .DRAIN_CYCLES(DRN_N), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .exit_code_i(exit_code), .activity_i(act),
    .ext_rst_req_i(ext), .dut_rst_no(dut_rst_no), .running_o(running),
    .exit_valid_o(exit_valid), .exit_code_o(exit_code_q), .exit_src_o(exit_src),
    .timeout_o(timeout), .finish_o(finish), .cycle_cnt_o(cycle_cnt), .state_o(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [EV_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic ev_t got_snap(input int kind, input int stamp);
    ev_t e;
    e.kind = 2'(kind); e.stamp = 32'(stamp); e.run = running; e.rstn = dut_rst_no;
    e.valid = exit_valid; e.code = exit_code_q; e.src = exit_src; e.tmo = timeout;
    e.fin = finish; e.cnt = cycle_cnt;
    return e;
  endfunction

  task automatic cmp(input string name, input ev_t got, input ev_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got kind=%0d cyc=%0d run=%0b rstn=%0b valid=%0b code=%h src=%0d tmo=%0b fin=%0b cnt=%0d | required kind=%0d cyc=%0d run=%0b rstn=%0b valid=%0b code=%h src=%0d tmo=%0b fin=%0b cnt=%0d",
               name, got.kind, got.stamp, got.run, got.rstn, got.valid, got.code, got.src, got.tmo, got.fin, got.cnt,
               exp.kind, exp.stamp, exp.run, exp.rstn, exp.valid, exp.code, exp.src, exp.tmo, exp.fin, exp.cnt);
    end
  endtask

  task automatic check_event(input int kind);
    ev_t got, exp;
    got = got_snap(kind, cyc);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d at cyc=%0d, required no event", kind, cyc);
    end else begin
      exp = exp_q.pop_front();
      cmp("event", got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic p_rstn = 1'b0, p_valid = 1'b0, p_fin = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut_rst_no != p_rstn)  check_event(dut_rst_no ? EV_RISE : EV_FALL);
      if (exit_valid && !p_valid) check_event(EV_EXIT);
      if (finish && !p_fin)       check_event(EV_FIN);
    end
    p_rstn  = dut_rst_no;
    p_valid = exit_valid;
    p_fin   = finish;
  end

  // ---------------- reference model ----------------
  int                m_phase, m_hold, m_idle, m_drained;
  logic [CNT_W-1:0]  m_cnt;
  logic              o_run, o_rstn, o_valid, o_tmo, o_fin, o_src;
  logic [CODE_W-1:0] o_code;

  task automatic model_reset();
    m_phase = PH_HOLD; m_hold = 0; m_idle = 0; m_drained = 0; m_cnt = '0;
    o_run = 0; o_rstn = 0; o_valid = 0; o_tmo = 0; o_fin = 0; o_src = 0; o_code = '0;
  endtask

  function automatic ev_t model_snap(input int kind, input int stamp);
    ev_t e;
    e.kind = 2'(kind); e.stamp = 32'(stamp); e.run = o_run; e.rstn = o_rstn;
    e.valid = o_valid; e.code = o_code; e.src = o_src; e.tmo = o_tmo; e.fin = o_fin; e.cnt = m_cnt;
    return e;
  endfunction

  task automatic bump_cnt();
    if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
  endtask

  // Predicts the outcome of one clock edge given the inputs applied before it.
  task automatic model_edge(input logic [N_SRC*CODE_W-1:0] codes, input logic a, input logic e, input int stamp);
    int win;
    win = -1;
    for (int k = 0; k < N_SRC; k++)
      if (win < 0 && codes[k*CODE_W +: CODE_W] != 0) win = k;
    case (m_phase)
      PH_HOLD: begin
        m_hold++;
        if (m_hold == HOLD_N) begin
          m_phase = PH_RUN; m_idle = 0; o_run = 1; o_rstn = 1;
          exp_q.push_back(model_snap(EV_RISE, stamp));
        end
      end
      PH_RUN: begin
        bump_cnt();
        if (win >= 0) begin
          o_valid = 1; o_code = codes[win*CODE_W +: CODE_W]; o_src = 1'(win); o_tmo = 0;
          o_run = 0; m_phase = PH_DRAIN; m_drained = 0;
          exp_q.push_back(model_snap(EV_EXIT, stamp));
        end else if (!a && m_idle + 1 == WDT_N) begin
          o_valid = 1; o_code = '1; o_src = 0; o_tmo = 1;
          o_run = 0; m_phase = PH_DRAIN; m_drained = 0;
          exp_q.push_back(model_snap(EV_EXIT, stamp));
        end else if (e) begin
          m_phase = PH_HOLD; m_hold = 0; m_idle = 0; m_cnt = '0; o_run = 0; o_rstn = 0;
          exp_q.push_back(model_snap(EV_FALL, stamp));
        end else begin
          m_idle = a ? 0 : m_idle + 1;
        end
      end
      PH_DRAIN: begin
        bump_cnt();
        m_drained++;
        if (m_drained == ((DRN_N == 0) ? 1 : DRN_N)) begin
          m_phase = PH_DONE; o_fin = 1;
          exp_q.push_back(model_snap(EV_FIN, stamp));
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [N_SRC*CODE_W-1:0] codes, input logic a, input logic e);
    exit_code = codes; act = a; ext = e;
    model_edge(codes, a, e, cyc + 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [CODE_W-1:0] hold_c0);
    ev_t zero;
    zero = '0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    exit_code = {{CODE_W{1'b0}}, hold_c0}; act = 1'b0; ext = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d unseen events, required 0", exp_q.size());
      exp_q.delete();
    end
    model_reset();
    #1;
    cmp("async_reset", got_snap(0, 0), zero);
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_held", got_snap(0, 0), zero);
    rst_n = 1'b1;
  endtask

  // act_mode: 0 never, >0 pulse period, <0 random 1-in-4.
  task automatic episode(input int act_mode, input int exit_at, input logic [CODE_W-1:0] c0,
                         input logic [CODE_W-1:0] c1, input int ext_at, input logic [CODE_W-1:0] hold_c0,
                         input int rst_drain_at, input int max_steps);
    logic [N_SRC*CODE_W-1:0] codes;
    logic a, e, was_run;
    int run_idx, tail, steps;
    bit ext_done;
    run_idx = 0; tail = 0; steps = 0; ext_done = 0;
    do_reset(hold_c0);
    while (steps < max_steps && tail < 8) begin
      if (m_phase == PH_DRAIN && m_drained == rst_drain_at) begin
        do_reset(32'h0);
        return;
      end
      codes = '0; a = 1'b0; e = 1'b0;
      case (m_phase)
        PH_HOLD: begin
          codes = {{CODE_W{1'b0}}, hold_c0};
          a = 1'($urandom_range(0, 1)); e = 1'($urandom_range(0, 1));
        end
        PH_RUN: begin
          if (hold_c0 != 0) codes = {{CODE_W{1'b0}}, hold_c0};
          else if (run_idx == exit_at && (ext_at < 0 || ext_done)) codes = {c1, c0};
          if (act_mode > 0)      a = ((run_idx % act_mode) == act_mode - 1);
          else if (act_mode < 0) a = ($urandom_range(0, 3) == 0);
          e = (run_idx == ext_at) && !ext_done;
        end
        default: begin
          codes = {$urandom, $urandom};
          a = 1'($urandom_range(0, 1)); e = 1'($urandom_range(0, 1));
        end
      endcase
      was_run = (m_phase == PH_RUN);
      if (m_phase == PH_DONE) tail++;
      step(codes, a, e);
      steps++;
      if (was_run) begin
        if (m_phase == PH_HOLD) begin ext_done = 1; run_idx = 0; end
        else run_idx++;
      end
    end
    if (m_phase == PH_DONE) cmp("done_sticky", got_snap(0, 0), model_snap(0, 0));
  endtask

  initial begin
    logic [CODE_W-1:0] r0, r1;
    int am;
    model_reset();
    episode(3, 30, 32'h0, 32'h5, -1, 32'h0, -1, 3000);
    episode(3, 10, 32'h2, 32'h7, -1, 32'h0, -1, 3000);
    episode(0, -1, 32'h0, 32'h0, -1, 32'h0, -1, 3000);
    episode(50, 10000, 32'h0, 32'h1234, -1, 32'h0, -1, 12000);
    episode(0, 99, 32'h9, 32'h0, -1, 32'h0, -1, 3000);
    episode(-1, 40, 32'h0, 32'hABCD, 200, 32'h0, -1, 3000);
    episode(3, 20, 32'h77, 32'h0, -1, 32'h0, 10, 3000);
    episode(3, -1, 32'h0, 32'h0, -1, 32'h3C, -1, 3000);
    for (int r = 0; r < 6; r++) begin
      r0 = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
      r1 = ($urandom_range(0, 1) == 1 || r0 == 0) ? ($urandom | 32'h1) : 32'h0;
      case ($urandom_range(0, 2))
        0:       am = 0;
        1:       am = 7;
        default: am = -1;
      endcase
      episode(am, $urandom_range(0, 250), r0, r1,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 150)) : -1, 32'h0, -1, 3000);
    end
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d unseen events, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL time_limit: simulation exceeded its time budget");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sim_exit_ctrl.md
Name: sim_exit_ctrl

Overview:
- Parametrised simulation harness controller that sits between the sim top-level and the SoC under test.
- Generalises single-source JTAG-exit handling to N exit sources with priority and a latched exit code.
- Adds a post-reset hold sequencer for the DUT, an activity watchdog with timeout, and a drain window before a finish request.
- The sim top-level calls $finish when finish_o asserts, so UART and other outputs flush before the simulation ends.

Parameters:
- N_SRC, 2, number of exit-code sources; index 0 has the highest priority.
- CODE_W, 32, width of each exit code.
- RST_HOLD_CYCLES, 16, cycles dut_rst_no is held low after controller reset; range 1..65535.
- WDT_CYCLES, 1000000, RUN cycles without activity before timeout; 0 disables the watchdog.
- DRAIN_CYCLES, 64, cycles spent in DRAIN before finish_o asserts; 0 is legal.
- CNT_W, 48, width of the cycle counter.

Ports:
- clk_i, input, 1, sole clock.
- rst_ni, input, 1, asynchronous active-low reset.
- exit_code_i, input, N_SRC*CODE_W, packed exit codes; source k occupies bits [k*CODE_W +: CODE_W]; nonzero means exit requested.
- activity_i, input, 1, watchdog kick (level).
- ext_rst_req_i, input, 1, request to re-run the DUT reset sequence.
- dut_rst_no, output, 1, active-low reset to the DUT.
- running_o, output, 1, high in RUN.
- exit_valid_o, output, 1, exit code/source latched.
- exit_code_o, output, CODE_W, latched exit code.
- exit_src_o, output, max(1,$clog2(N_SRC)), latched source index.
- timeout_o, output, 1, exit was caused by the watchdog.
- finish_o, output, 1, request to end the simulation.
- cycle_cnt_o, output, CNT_W, cycles spent in RUN plus DRAIN.

Behaviour:
- Reset: one clock; rst_ni is asynchronous assert, synchronous deassert. On reset, state=HOLD and all outputs are 0: dut_rst_no=0, running_o=0, exit_valid_o=0, exit_code_o=0, exit_src_o=0, timeout_o=0, finish_o=0, cycle_cnt_o=0. The hold and watchdog counters are also 0.
- States and transitions:
  - HOLD → RUN: hold counter increments each cycle. When it reaches RST_HOLD_CYCLES-1, go to RUN. dut_rst_no goes to 1 in the first RUN cycle, i.e. the DUT sees exactly RST_HOLD_CYCLES low cycles.
  - RUN, exit: registered dut_rst_no=1 and running_o=1. Each cycle exit_code_i is scanned; the lowest index k with a nonzero code wins. On the next edge, latch exit_code_o=code[k], exit_src_o=k, exit_valid_o=1, then go to DRAIN.
  - RUN, watchdog: the watchdog counter clears in any cycle where activity_i=1, otherwise it increments. With WDT_CYCLES≠0 and the counter equal to WDT_CYCLES-1 with no activity, latch exit_code_o=all ones, exit_src_o=0, timeout_o=1, exit_valid_o=1, then go to DRAIN.
  - RUN, external reset: if ext_rst_req_i=1 and there is no exit or timeout this cycle, go to HOLD. This clears the hold counter, watchdog counter and cycle_cnt_o, and drives dut_rst_no=0 from the next cycle.
  - DRAIN: running_o=0, dut_rst_no stays 1 so the DUT keeps running. The drain counter counts DRAIN_CYCLES cycles, then goes to DONE. With DRAIN_CYCLES=0, go to DONE on the first DRAIN cycle.
  - DONE: finish_o=1, sticky until rst_ni. Terminal state.
- Priority within a RUN cycle: exit source > watchdog timeout > ext_rst_req_i. An exit in the same cycle as the timeout sets timeout_o=0 and latches the source code.
- Inputs ignored:
  - exit_code_i in HOLD, DRAIN and DONE; latched values never change after exit_valid_o rises.
  - ext_rst_req_i in HOLD, DRAIN and DONE.
  - activity_i outside RUN.
- cycle_cnt_o: increments in RUN and DRAIN, saturates at all ones, frozen in DONE.
- Reset mid-operation: any state returns to HOLD with reset values and the DUT reset re-sequences. A nonzero exit_code_i held across reset is captured in the first RUN cycle.

Test Plan:
- Reset release with RST_HOLD_CYCLES=16 → dut_rst_no rises exactly 16 cycles after reset release; running_o rises the same cycle.
- In RUN, drive src1=0x0000_0005 and src0=0 for 1 cycle, DRAIN_CYCLES=64 → exit_valid_o=1, exit_src_o=1, exit_code_o=5 next cycle; finish_o rises 64 cycles later and stays high.
- Same cycle: src0=0x2 and src1=0x7 → exit_src_o=0, exit_code_o=2.
- WDT_CYCLES=100, activity_i=0 → timeout_o=1 and exit_code_o=0xFFFF_FFFF after 100 RUN cycles; with an activity pulse every 50 cycles, no timeout over 10000 cycles.
- Watchdog expiry and src0=0x9 in the same cycle → timeout_o=0, exit_code_o=9.
- ext_rst_req_i pulse after 200 RUN cycles → dut_rst_no low for 16 cycles, cycle_cnt_o=0. rst_ni asserted during DRAIN → all outputs return to 0 asynchronously.
